// File: rtl/ltc2308_responder.sv
// LTC2308-style SPI ADC responder: accepts CONVST/SCK/SDI from an initiator and returns sample_data on SDO.
// Build option LTC2308_BIPOLAR_EN: when UNI=0, bit 11 of the captured sample is inverted (two's complement output).
module ltc2308_responder #(
  parameter int TCONV_TICKS = 52
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_convst,
  input  logic        i_sck,
  input  logic        i_sdi,
  output logic        o_sdo,
  output logic        o_sample_req,
  output logic [3:0]  o_sample_chan,
  input  logic [11:0] i_sample_data,
  output logic [5:0]  o_cfg_word,
  output logic        o_cfg_valid,
  output logic        o_asleep
);

  localparam int CW = (TCONV_TICKS > 2) ? $clog2(TCONV_TICKS) : 1;
  localparam logic [CW-1:0] CONV_LOAD = CW'(TCONV_TICKS - 1);
  localparam logic [5:0] CFG_RESET = 6'b100010;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_READOUT = 2'd2,
    ST_SLEEP   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic r_convst_s1, r_convst_s2, r_convst_d;
  logic r_sck_s1, r_sck_s2, r_sck_d;
  logic r_sdi_s1, r_sdi_s2;

  logic [CW-1:0] r_conv_cnt;
  logic [11:0]   r_shift;
  logic [3:0]    r_rise_cnt;
  logic [3:0]    r_fall_cnt;
  logic [4:0]    r_cfg_sh;
  logic [5:0]    r_cfg_word;
  logic          r_cfg_valid;
  logic          r_sample_req;
  logic [3:0]    r_sample_chan;

  logic          w_convst_rise;
  logic          w_sck_rise;
  logic          w_sck_fall;
  logic          w_start;
  logic          w_capture;
  logic [3:0]    w_chan_map;
  logic [11:0]   w_capture_data;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_convst_s1 <= 1'b0;
      r_convst_s2 <= 1'b0;
      r_convst_d  <= 1'b0;
      r_sck_s1    <= 1'b0;
      r_sck_s2    <= 1'b0;
      r_sck_d     <= 1'b0;
      r_sdi_s1    <= 1'b0;
      r_sdi_s2    <= 1'b0;
    end else begin
      r_convst_s1 <= i_convst;
      r_convst_s2 <= r_convst_s1;
      r_convst_d  <= r_convst_s2;
      r_sck_s1    <= i_sck;
      r_sck_s2    <= r_sck_s1;
      r_sck_d     <= r_sck_s2;
      r_sdi_s1    <= i_sdi;
      r_sdi_s2    <= r_sdi_s1;
    end
  end

  assign w_convst_rise = r_convst_s2 & ~r_convst_d;
  assign w_sck_rise    = r_sck_s2 & ~r_sck_d;
  assign w_sck_fall    = ~r_sck_s2 & r_sck_d;

  // cfg bits: [5]=S/D [4]=O/S [3]=S1 [2]=S0 [1]=UNI [0]=SLP
  assign w_chan_map = r_cfg_word[5] ? {1'b0, r_cfg_word[3], r_cfg_word[2], r_cfg_word[4]}
                                    : {1'b1, r_cfg_word[4], r_cfg_word[3], r_cfg_word[2]};

`ifdef LTC2308_BIPOLAR_EN
  logic r_conv_uni;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_conv_uni <= 1'b1;
    end else if (w_start) begin
      r_conv_uni <= r_cfg_word[1];
    end
  end

  assign w_capture_data = r_conv_uni ? i_sample_data : {~i_sample_data[11], i_sample_data[10:0]};
`else
  assign w_capture_data = i_sample_data;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_convst_rise) begin
          w_state_next = ST_CONVERT;
          w_start      = 1'b1;
        end
      end
      ST_CONVERT: begin
        if (r_conv_cnt == '0) begin
          w_state_next = ST_READOUT;
          w_capture    = 1'b1;
        end
      end
      ST_READOUT: begin
        // A new CONVST wins over a simultaneous 12th SCK fall.
        if (w_convst_rise) begin
          w_state_next = ST_CONVERT;
          w_start      = 1'b1;
        end else if (w_sck_fall && r_fall_cnt == 4'd11) begin
          w_state_next = r_cfg_word[0] ? ST_SLEEP : ST_IDLE;
        end
      end
      ST_SLEEP: begin
        if (w_convst_rise) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_conv_cnt    <= '0;
      r_shift       <= '0;
      r_rise_cnt    <= '0;
      r_fall_cnt    <= '0;
      r_cfg_sh      <= '0;
      r_cfg_word    <= CFG_RESET;
      r_cfg_valid   <= 1'b0;
      r_sample_req  <= 1'b0;
      r_sample_chan <= '0;
    end else begin
      r_sample_req <= w_start;
      r_cfg_valid  <= 1'b0;
      if (w_start) begin
        r_sample_chan <= w_chan_map;
        r_conv_cnt    <= CONV_LOAD;
        r_rise_cnt    <= '0;
        r_fall_cnt    <= '0;
        r_cfg_sh      <= '0;
      end else if (r_state == ST_CONVERT && r_conv_cnt != '0) begin
        r_conv_cnt <= r_conv_cnt - CW'(1);
      end
      if (w_capture) begin
        r_shift <= w_capture_data;
      end
      if (r_state == ST_READOUT && !w_convst_rise) begin
        if (w_sck_rise && r_rise_cnt != 4'd12) begin
          r_rise_cnt <= r_rise_cnt + 4'd1;
          // The first rising edge holds bit 11 so the initiator sees it for a full SCK period.
          if (r_rise_cnt != 4'd0) begin
            r_shift <= {r_shift[10:0], 1'b0};
          end
          if (r_rise_cnt < 4'd6) begin
            r_cfg_sh <= {r_cfg_sh[3:0], r_sdi_s2};
            if (r_rise_cnt == 4'd5) begin
              r_cfg_word  <= {r_cfg_sh, r_sdi_s2};
              r_cfg_valid <= 1'b1;
            end
          end
        end
        if (w_sck_fall && r_fall_cnt != 4'd12) begin
          r_fall_cnt <= r_fall_cnt + 4'd1;
        end
      end
    end
  end

  assign o_sdo         = (r_state == ST_READOUT) & r_shift[11];
  assign o_sample_req  = r_sample_req;
  assign o_sample_chan = r_sample_chan;
  assign o_cfg_word    = r_cfg_word;
  assign o_cfg_valid   = r_cfg_valid;
  assign o_asleep      = (r_state == ST_SLEEP);

endmodule

// File: tb/tb_ltc2308_responder.sv
// Directed scoreboard bench for ltc2308_responder; expected channel, config and readout words are queued at stimulus time.
module tb_ltc2308_responder;
  localparam int TCONV = 52;
  localparam int HALF  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        convst = 1'b0;
  logic        sck = 1'b0;
  logic        sdi = 1'b0;
  logic        sdo;
  logic        sample_req;
  logic [3:0]  sample_chan;
  logic [11:0] sample_data = 12'h000;
  logic [5:0]  cfg_word;
  logic        cfg_valid;
  logic        asleep;

  int n_checks = 0;
  int n_errors = 0;
  int n_req = 0;
  int n_cfgv = 0;

  logic [3:0]  chan_q[$];
  logic [5:0]  cfg_q[$];
  logic [11:0] data_q[$];

  ltc2308_responder #(.TCONV_TICKS(TCONV)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_convst      (convst),
    .i_sck         (sck),
    .i_sdi         (sdi),
    .o_sdo         (sdo),
    .o_sample_req  (sample_req),
    .o_sample_chan (sample_chan),
    .i_sample_data (sample_data),
    .o_cfg_word    (cfg_word),
    .o_cfg_valid   (cfg_valid),
    .o_asleep      (asleep)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sample_req) begin
      n_req++;
      chk("req_expected", chan_q.size() > 0, 1);
      if (chan_q.size() > 0) chk("sample_chan", sample_chan, chan_q.pop_front());
    end
    if (cfg_valid) begin
      n_cfgv++;
      chk("cfgv_expected", cfg_q.size() > 0, 1);
      if (cfg_q.size() > 0) chk("cfg_word", cfg_word, cfg_q.pop_front());
    end
  end

  task automatic pulse_convst();
    @(negedge clk) convst = 1'b1;
    repeat (4) @(negedge clk);
    convst = 1'b0;
  endtask

  task automatic do_conv(input logic [11:0] data, input logic [3:0] exp_chan, input logic [11:0] exp_data);
    sample_data = data;
    chan_q.push_back(exp_chan);
    data_q.push_back(exp_data);
    pulse_convst();
    repeat (TCONV + 8) @(negedge clk);
  endtask

  task automatic sck_cycle();
    repeat (HALF) @(negedge clk);
    sck = 1'b1;
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic readout(input int ncyc, input logic [5:0] word);
    logic [11:0] got;
    got = '0;
    if (ncyc >= 6) cfg_q.push_back(word);
    for (int i = 0; i < ncyc; i++) begin
      sdi = (i < 6) ? word[5-i] : 1'b0;
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      got = {got[10:0], sdo};
      sck = 1'b0;
    end
    sdi = 1'b0;
    if (ncyc == 12) begin
      repeat (HALF) @(negedge clk);
      chk("readout", got, data_q.pop_front());
      chk("sdo_after_12", sdo, 1'b0);
      sck_cycle();
      repeat (HALF) @(negedge clk);
      chk("sdo_extra_sck", sdo, 1'b0);
    end
  endtask

  initial begin
    int lat;
    int req_save;
    int cfgv_save;
    logic [11:0] bip_exp;

    repeat (3) @(negedge clk);
    chk("rst_sdo", sdo, 1'b0);
    chk("rst_req", sample_req, 1'b0);
    chk("rst_cfgv", cfg_valid, 1'b0);
    chk("rst_asleep", asleep, 1'b0);
    chk("rst_chan", sample_chan, 4'd0);
    chk("rst_cfg", cfg_word, 6'b100010);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Conversion 1: default config, check SDO latency
    sample_data = 12'hA5C;
    chan_q.push_back(4'd0);
    data_q.push_back(12'hA5C);
    convst = 1'b1;
    lat = 0;
    while (sdo !== 1'b1 && lat < 80) begin
      @(negedge clk);
      lat++;
      if (lat == 4) convst = 1'b0;
    end
    convst = 1'b0;
    chk("sdo_latency_le55", (lat >= TCONV) && (lat <= 55), 1);
    readout(12, 6'b110010);

    do_conv(12'h123, 4'd1, 12'h123);
    readout(12, 6'b010000);

    do_conv(12'hFFF, 4'd12, 12'hFFF);
    readout(12, 6'b100000);

`ifdef LTC2308_BIPOLAR_EN
    bip_exp = 12'h000;
`else
    bip_exp = 12'h800;
`endif
    do_conv(12'h800, 4'd0, bip_exp);
    readout(12, 6'b100010);

    // Abort after 3 SCK cycles
    do_conv(12'h3C7, 4'd0, 12'h3C7);
    cfgv_save = n_cfgv;
    readout(3, 6'b110110);
    void'(data_q.pop_front());
    do_conv(12'h5A1, 4'd0, 12'h5A1);
    chk("abort_cfg", cfg_word, 6'b100010);
    chk("abort_no_cfgv", n_cfgv, cfgv_save);
    readout(12, 6'b100011);
    chk("sleep_asleep", asleep, 1'b1);
    chk("sleep_sdo", sdo, 1'b0);

    req_save = n_req;
    pulse_convst();
    repeat (10) @(negedge clk);
    chk("wake_no_req", n_req, req_save);
    chk("wake_asleep", asleep, 1'b0);

    do_conv(12'h0F0, 4'd0, 12'h0F0);
    readout(12, 6'b110010);
    chk("post_asleep", asleep, 1'b0);

    // Reset mid-conversion discards the sample and restores config
    sample_data = 12'hFFF;
    chan_q.push_back(4'd1);
    pulse_convst();
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_cfg", cfg_word, 6'b100010);
    chk("midrst_chan", sample_chan, 4'd0);
    chk("midrst_sdo", sdo, 1'b0);
    rst = 1'b0;
    repeat (TCONV + 20) @(negedge clk);
    chk("midrst_sdo_later", sdo, 1'b0);
    chk("midrst_asleep", asleep, 1'b0);

    chk("chan_q_empty", chan_q.size(), 0);
    chk("cfg_q_empty", cfg_q.size(), 0);
    chk("data_q_empty", data_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
